ff_mem_arb: RTL and testbench
=============================

# ff_mem_arb

Single-port memory arbiter for the foodfight core: shares one external/on-chip SRAM port between the video fetch engine, the 68000 CPU bus and the ROM/RAM loader. Video has absolute priority (scan-out deadline); CPU and loader alternate round-robin. It sits inside ff_top, between the requesters and the memory pins, in the clk12m domain.

## Interface
- AW, 18, memory word-address width
- DW, 16, memory data width
- ACC_CYC, 2, cycles the memory is driven per access (≥1)

- clk12m  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- vid_req  in  1  video read request (level, held until ack)
- vid_addr  in  AW  video read address
- vid_ack  out  1  one-cycle pulse; rdata valid this cycle
- cpu_req  in  1  CPU request (level, held until ack)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- ldr_req  in  1  loader write request (write-only)
- ldr_addr  in  AW  loader address
- ldr_wdata  in  DW  loader write data
- ldr_ack  out  1  one-cycle completion pulse
- rdata  out  DW  read data, valid with vid_ack/cpu_ack
- mem_addr  out  AW  memory address (registered)
- mem_wdata  out  DW  memory write data (registered)
- mem_we  out  1  memory write enable, active high
- mem_oe  out  1  memory output enable, active high
- mem_rdata  in  DW  memory read data
- cpu_stall_cnt  out  16  CPU wait-cycle counter (see Configuration)

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req, select grantee, latch its addr/wdata/we into mem_* registers, load access counter = ACC_CYC-1, go ACCESS. No req: stay IDLE.
- Selection: vid_req wins whenever high. Otherwise CPU vs loader round-robin: the one not granted last wins when both request; pointer updates only on CPU/loader grants (video grants leave it unchanged). Pointer reset value favours CPU.
- ACCESS: mem_oe=1 for reads, mem_we=1 for writes, mem_addr/mem_wdata stable; counter decrements; on counter=0 capture mem_rdata into rdata (reads only), go DONE.
- DONE: pulse the grantee's ack exactly one cycle, deassert mem_we/mem_oe, return to IDLE.
- Request inputs are sampled only in IDLE; a req dropped mid-access does not abort — the access completes and ack still pulses.
- rdata holds its last captured value between reads; writes do not alter it.
- Reset values: all acks 0, mem_we 0, mem_oe 0, mem_addr 0, mem_wdata 0, rdata 0, state IDLE, cpu_stall_cnt 0. Reset asserted mid-access aborts immediately; no ack is ever issued for the aborted access.

## Timing
- Grant decision combinational in IDLE; mem_* registered, valid cycle after req seen.
- Req-to-ack latency with idle arbiter: ACC_CYC+2 cycles (ACC_CYC=2 → ack 4 cycles after req sampled).
- Throughput: one access per ACC_CYC+2 cycles; a requester holding req after ack is sampled again in the following IDLE cycle.
- Worst-case CPU wait: one in-flight access + continuous video + one loader access.
- Simultaneous vid/cpu/ldr in IDLE: video first, then CPU/loader per pointer.

## Configuration
- FF_MEMARB_STALL_CNT_EN defined: cpu_stall_cnt counts cycles with cpu_req high and cpu_ack low, saturating at 16'hFFFF, cleared only by reset.
- Undefined: counter logic omitted, cpu_stall_cnt tied to 0.

## Structure
- Package ff_mem_pkg: FSM state enum, requester-ID encoding (REQ_VID, REQ_CPU, REQ_LDR), default AW/DW constants.
- Sub-module ff_rr_arb2: two-way round-robin picker with pointer register, used for CPU/loader selection.

## Test plan
- CPU read 0x00123 alone, mem_rdata=16'hBEEF, ACC_CYC=2 -> mem_oe high 2 cycles, cpu_ack 4 cycles after req, rdata=16'hBEEF.
- vid_req and cpu_req together in IDLE -> video served first, CPU ack follows after second access; no overlap of mem_oe/mem_we.
- cpu_req and ldr_req held continuously -> grants alternate CPU, LDR, CPU, LDR; pointer unchanged by interleaved video grants.
- Loader write 0x3FFFF/16'h1234 -> mem_we high exactly ACC_CYC cycles with stable addr/data; rdata unchanged; ldr_ack single pulse.
- reset low during ACCESS -> mem_we/mem_oe drop immediately, no ack after release, next req served normally.
- With FF_MEMARB_STALL_CNT_EN, CPU blocked by 10 video accesses -> cpu_stall_cnt equals waited cycles; without macro reads 0.

Source files
------------

// File: rtl/ff_mem_pkg.sv
// Shared types and default widths for the foodfight single-port memory arbiter.
package ff_mem_pkg;

   localparam int FF_AW = 18;
   localparam int FF_DW = 16;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_e;

   typedef enum logic [1:0] {REQ_VID, REQ_CPU, REQ_LDR} req_id_e;

endpackage

// File: rtl/ff_rr_arb2.sv
// Two-way round-robin picker: when both request, the side that did not win last time wins.
module ff_rr_arb2 (
   input  logic clk,
   input  logic rst_n,
   input  logic req_a,
   input  logic req_b,
   input  logic update,
   output logic gnt_a,
   output logic gnt_b
);

   // Set when b won the most recent arbitration; the reset value lets a win the first tie.
   logic last_b;

   always_comb begin
      gnt_a = req_a & (~req_b | last_b);
      gnt_b = req_b & ~gnt_a;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_b <= 1'b1;
      else if (update && (gnt_a || gnt_b))
         last_b <= gnt_b;
   end

endmodule

// File: rtl/ff_mem_arb.sv
// Single-port SRAM arbiter: video has absolute priority, CPU and loader alternate round-robin.
// Define FF_MEMARB_STALL_CNT_EN to build the saturating CPU wait-cycle counter.
module ff_mem_arb
   import ff_mem_pkg::*;
#(
   parameter int AW      = FF_AW,
   parameter int DW      = FF_DW,
   parameter int ACC_CYC = 2
) (
   input  logic          clk12m,
   input  logic          reset,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_ack,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   input  logic          ldr_req,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic          ldr_ack,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   output logic          mem_oe,
   input  logic [DW-1:0] mem_rdata,
   output logic [15:0]   cpu_stall_cnt
);

   localparam int CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;

   arb_state_e    state, state_nxt;
   req_id_e       gnt_id, owner;
   logic          start, rr_update, rr_gnt_cpu, rr_gnt_ldr;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic [CW-1:0] acc_cnt;

   ff_rr_arb2 u_rr (
      .clk    (clk12m),
      .rst_n  (reset),
      .req_a  (cpu_req),
      .req_b  (ldr_req),
      .update (rr_update),
      .gnt_a  (rr_gnt_cpu),
      .gnt_b  (rr_gnt_ldr)
   );

   always_ff @(posedge clk12m or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Requests are only looked at in IDLE; video bypasses the round-robin pointer entirely.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      rr_update = 1'b0;
      gnt_id    = REQ_VID;
      sel_we    = 1'b0;
      sel_addr  = vid_addr;
      sel_wdata = '0;
      case (state)
         IDLE: begin
            if (vid_req) begin
               start     = 1'b1;
               state_nxt = ACCESS;
            end else if (rr_gnt_cpu) begin
               start     = 1'b1;
               rr_update = 1'b1;
               gnt_id    = REQ_CPU;
               sel_we    = cpu_we;
               sel_addr  = cpu_addr;
               sel_wdata = cpu_wdata;
               state_nxt = ACCESS;
            end else if (rr_gnt_ldr) begin
               start     = 1'b1;
               rr_update = 1'b1;
               gnt_id    = REQ_LDR;
               sel_we    = 1'b1;
               sel_addr  = ldr_addr;
               sel_wdata = ldr_wdata;
               state_nxt = ACCESS;
            end
         end
         ACCESS:  if (acc_cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk12m or negedge reset) begin
      if (!reset) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         mem_oe    <= 1'b0;
         rdata     <= '0;
         vid_ack   <= 1'b0;
         cpu_ack   <= 1'b0;
         ldr_ack   <= 1'b0;
         acc_cnt   <= '0;
         owner     <= REQ_VID;
      end else begin
         vid_ack <= 1'b0;
         cpu_ack <= 1'b0;
         ldr_ack <= 1'b0;
         if (start) begin
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_we    <= sel_we;
            mem_oe    <= ~sel_we;
            owner     <= gnt_id;
            acc_cnt   <= CW'(ACC_CYC - 1);
         end else if (state == ACCESS) begin
            // Last drive cycle: release the bus and raise the ack that will be seen in DONE.
            if (acc_cnt == '0) begin
               mem_we  <= 1'b0;
               mem_oe  <= 1'b0;
               if (mem_oe)
                  rdata <= mem_rdata;
               vid_ack <= (owner == REQ_VID);
               cpu_ack <= (owner == REQ_CPU);
               ldr_ack <= (owner == REQ_LDR);
            end else begin
               acc_cnt <= acc_cnt - 1'b1;
            end
         end
      end
   end

`ifdef FF_MEMARB_STALL_CNT_EN
   logic [15:0] stall_cnt;

   always_ff @(posedge clk12m or negedge reset) begin
      if (!reset)
         stall_cnt <= '0;
      else if (cpu_req && !cpu_ack && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end

   assign cpu_stall_cnt = stall_cnt;
`else
   assign cpu_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ff_mem_arb.sv
// Bench for ff_mem_arb: transaction-timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized request traffic.
module tb_ff_mem_arb;

   localparam int AW      = 18;
   localparam int DW      = 16;
   localparam int ACC_CYC = 2;
   localparam int V = 0;
   localparam int C = 1;
   localparam int L = 2;

   logic          clk12m = 1'b0;
   logic          reset  = 1'b0;
   logic          vid_req = 1'b0;
   logic [AW-1:0] vid_addr = '0;
   logic          vid_ack;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_ack;
   logic          ldr_req = 1'b0;
   logic [AW-1:0] ldr_addr = '0;
   logic [DW-1:0] ldr_wdata = '0;
   logic          ldr_ack;
   logic [DW-1:0] rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic          mem_oe;
   logic [DW-1:0] mem_rdata = '0;
   logic [15:0]   cpu_stall_cnt;

   always #5 clk12m = ~clk12m;

   ff_mem_arb #(.AW(AW), .DW(DW), .ACC_CYC(ACC_CYC)) dut (
      .clk12m(clk12m), .reset(reset),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
      .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
      .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_oe(mem_oe),
      .mem_rdata(mem_rdata), .cpu_stall_cnt(cpu_stall_cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
   endtask

   function automatic logic [15:0] dflt(input int a);
      return 16'(a) ^ 16'h5A3C;
   endfunction

   // External SRAM seen by the DUT
   logic [15:0] sram [int];
   function automatic logic [15:0] sram_rd(input int a);
      if (sram.exists(a)) return sram[a];
      return dflt(a);
   endfunction
   always @(posedge clk12m) if (mem_we) sram[int'(mem_addr)] = mem_wdata;
   always @(negedge clk12m) mem_rdata = sram_rd(int'(mem_addr));

   // Reference model: one transaction at a time, each occupying ACC_CYC+2 cycles
   // (decision cycle, ACC_CYC drive cycles, ack cycle).
   logic [15:0]   mm [int];
   int            cyc = 0;
   int            m_tick = 0;
   int            m_own = V;
   logic          m_we = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wd = '0;
   logic [DW-1:0] m_rdata = '0;
   logic          m_cpu_next = 1'b1;
   logic [15:0]   m_stall = '0;
   logic          e_vack = 1'b0, e_cack = 1'b0, e_lack = 1'b0;
   logic          active;

   function automatic logic [15:0] mm_rd(input int a);
      if (mm.exists(a)) return mm[a];
      return dflt(a);
   endfunction

   always @(posedge clk12m) begin
      cyc++;
      if (!reset) begin
         m_tick = 0; m_rdata = '0; m_cpu_next = 1'b1; m_stall = '0;
      end else begin
         if (cpu_req && !e_cack && m_stall != 16'hFFFF) m_stall++;
         if (m_tick == 0) begin
            if (vid_req) begin
               m_own = V; m_addr = vid_addr; m_we = 1'b0; m_tick = 1;
            end else if (cpu_req && (!ldr_req || m_cpu_next)) begin
               m_own = C; m_addr = cpu_addr; m_we = cpu_we; m_wd = cpu_wdata; m_tick = 1;
               m_cpu_next = 1'b0;
            end else if (ldr_req) begin
               m_own = L; m_addr = ldr_addr; m_we = 1'b1; m_wd = ldr_wdata; m_tick = 1;
               m_cpu_next = 1'b1;
            end
         end else if (m_tick == ACC_CYC) begin
            if (m_we) mm[int'(m_addr)] = m_wd;
            else m_rdata = mm_rd(int'(m_addr));
            m_tick++;
         end else if (m_tick == ACC_CYC + 1) begin
            m_tick = 0;
         end else begin
            m_tick++;
         end
      end
      e_vack = (m_tick == ACC_CYC + 1) && (m_own == V);
      e_cack = (m_tick == ACC_CYC + 1) && (m_own == C);
      e_lack = (m_tick == ACC_CYC + 1) && (m_own == L);
      active = (m_tick >= 1) && (m_tick <= ACC_CYC);
      #1;
      chk("mem_oe", mem_oe, active && !m_we);
      chk("mem_we", mem_we, active && m_we);
      chk("vid_ack", vid_ack, e_vack);
      chk("cpu_ack", cpu_ack, e_cack);
      chk("ldr_ack", ldr_ack, e_lack);
      chk("rdata", rdata, m_rdata);
      if (active) begin
         chk("mem_addr", mem_addr, m_addr);
         if (m_we) chk("mem_wdata", mem_wdata, m_wd);
      end
`ifdef FF_MEMARB_STALL_CNT_EN
      chk("stall_cnt", cpu_stall_cnt, m_stall);
`else
      chk("stall_cnt", cpu_stall_cnt, 16'h0);
`endif
   end

   // Requester agents: hold counts say how many extra accesses to request back to back.
   int vid_hold = 0, cpu_hold = 0, ldr_hold = 0;
   int log_who[$];
   int log_cyc[$];
   int start_cyc = 0, oe_cnt = 0, we_cnt = 0, we_ok = 0;

   task automatic tick();
      @(negedge clk12m);
      if (reset) begin
         if (vid_ack) begin
            log_who.push_back(V); log_cyc.push_back(cyc);
            if (vid_hold > 0) begin vid_hold--; vid_addr = AW'($urandom_range(0, 63)); end
            else vid_req = 1'b0;
         end
         if (cpu_ack) begin
            log_who.push_back(C); log_cyc.push_back(cyc);
            if (cpu_hold > 0) begin
               cpu_hold--; cpu_addr = AW'($urandom_range(0, 63)); cpu_wdata = DW'($urandom);
            end else cpu_req = 1'b0;
         end
         if (ldr_ack) begin
            log_who.push_back(L); log_cyc.push_back(cyc);
            if (ldr_hold > 0) begin
               ldr_hold--; ldr_addr = AW'($urandom_range(0, 63)); ldr_wdata = DW'($urandom);
            end else ldr_req = 1'b0;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         if (mem_oe) oe_cnt++;
         if (mem_we) begin
            we_cnt++;
            if (mem_addr == 18'h3FFFF && mem_wdata == 16'h1234) we_ok++;
         end
      end
   endtask

   task automatic begin_txn();
      log_who.delete(); log_cyc.delete();
      oe_cnt = 0; we_cnt = 0; we_ok = 0; start_cyc = cyc;
   endtask

   function automatic int who_at(input int i);
      return (i < log_who.size()) ? log_who[i] : -1;
   endfunction

   function automatic int lat_at(input int i);
      return (i < log_cyc.size()) ? (log_cyc[i] - start_cyc + 1) : -1;
   endfunction

   int exp_seq [9] = '{C, L, V, C, L, C, L, C, L};

   initial begin
      repeat (3) tick();
      chk("rst_mem_oe", mem_oe, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_acks", {vid_ack, cpu_ack, ldr_ack}, 0);
      chk("rst_stall", cpu_stall_cnt, 0);
      reset = 1'b1;
      tick();

      // CPU blocked behind ten back-to-back video reads
      begin_txn();
      vid_req = 1'b1; vid_addr = 18'h00010; vid_hold = 9;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00050; cpu_hold = 0;
      run(50);
      chk("stall_n_acks", log_who.size(), 11);
      chk("stall_first_vid_lat", lat_at(0), 4);
      chk("stall_cpu_last", who_at(10), C);
      chk("stall_cpu_lat", lat_at(10), 44);
`ifdef FF_MEMARB_STALL_CNT_EN
      chk("stall_cnt_value", cpu_stall_cnt, 43);
`else
      chk("stall_cnt_value", cpu_stall_cnt, 0);
`endif

      // Loader seeds BEEF, then CPU reads it back alone
      begin_txn();
      ldr_req = 1'b1; ldr_addr = 18'h00123; ldr_wdata = 16'hBEEF;
      run(6);
      chk("seed_ldr_lat", lat_at(0), 4);
      begin_txn();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00123;
      run(8);
      chk("rd_oe_cycles", oe_cnt, 2);
      chk("rd_who", who_at(0), C);
      chk("rd_lat", lat_at(0), 4);
      chk("rd_n_acks", log_who.size(), 1);
      chk("rd_rdata", rdata, 16'hBEEF);

      // Video and CPU together: video first
      begin_txn();
      vid_req = 1'b1; vid_addr = 18'h00456;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00123;
      run(12);
      chk("vc_first", who_at(0), V);
      chk("vc_first_lat", lat_at(0), 4);
      chk("vc_second", who_at(1), C);
      chk("vc_second_lat", lat_at(1), 8);
      chk("vc_rdata", rdata, 16'hBEEF);

      // Loader write at the top address
      begin_txn();
      ldr_req = 1'b1; ldr_addr = 18'h3FFFF; ldr_wdata = 16'h1234;
      run(8);
      chk("lw_we_cycles", we_cnt, 2);
      chk("lw_we_stable", we_ok, 2);
      chk("lw_oe_cycles", oe_cnt, 0);
      chk("lw_n_acks", log_who.size(), 1);
      chk("lw_lat", lat_at(0), 4);
      chk("lw_rdata", rdata, 16'hBEEF);

      // CPU and loader held continuously, one video access dropped in mid-stream
      begin_txn();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'($urandom_range(0, 63)); cpu_hold = 3;
      ldr_req = 1'b1; ldr_addr = AW'($urandom_range(0, 63)); ldr_wdata = DW'($urandom); ldr_hold = 3;
      run(5);
      vid_req = 1'b1; vid_addr = 18'h00200; vid_hold = 0;
      run(40);
      chk("rr_n_acks", log_who.size(), 9);
      for (int i = 0; i < 9; i++) chk($sformatf("rr_seq_%0d", i), who_at(i), exp_seq[i]);

      // Reset in the middle of a CPU read
      begin_txn();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00077;
      tick();
      chk("mid_oe_before", mem_oe, 1);
      reset = 1'b0;
      cpu_req = 1'b0;
      #1;
      chk("mid_oe_after", mem_oe, 0);
      chk("mid_we_after", mem_we, 0);
      chk("mid_acks_after", {vid_ack, cpu_ack, ldr_ack}, 0);
      tick(); tick();
      reset = 1'b1;
      begin_txn();
      run(8);
      chk("mid_no_ack", log_who.size(), 0);
      begin_txn();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00123;
      run(8);
      chk("post_rst_who", who_at(0), C);
      chk("post_rst_lat", lat_at(0), 4);
      chk("post_rst_rdata", rdata, 16'hBEEF);

      // Randomized traffic, checked cycle by cycle against the model
      for (int i = 0; i < 700; i++) begin
         tick();
         if (!vid_req && $urandom_range(0, 99) < 15) begin
            vid_req = 1'b1; vid_addr = AW'($urandom_range(0, 63)); vid_hold = int'($urandom_range(0, 2));
         end
         if (!cpu_req && $urandom_range(0, 99) < 30) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = AW'($urandom_range(0, 63)); cpu_wdata = DW'($urandom);
            cpu_hold = int'($urandom_range(0, 2));
         end
         if (!ldr_req && $urandom_range(0, 99) < 25) begin
            ldr_req = 1'b1; ldr_addr = AW'($urandom_range(0, 63)); ldr_wdata = DW'($urandom);
            ldr_hold = int'($urandom_range(0, 2));
         end
      end
      vid_hold = 0; cpu_hold = 0; ldr_hold = 0;
      run(40);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
